sd_cic_decimator: RTL and testbench

Third-order CIC decimation filter converting the 1-bit sigma-delta modulator stream into DATA_LENGTH-bit signed samples and pushing them into the downstream sample FIFO through its write port. It sits between the modulator bitstream input and the FIFO's `i_data`/`write`/`full` signals. It drops samples when the FIFO is full and reports those drops, and it never writes while the FIFO reports full.

---
 rtl/sd_cic_decimator_pkg.sv | 23 ++
 rtl/sd_cic_decimator_integrator.sv | 27 ++
 rtl/sd_cic_decimator.sv | 168 ++++++++++++++++
 tb/tb_sd_cic_decimator.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sd_cic_decimator_pkg.sv
// rtl/sd_cic_decimator_pkg.sv - shared types and sizing helpers for the sigma-delta CIC decimator
package SDCICPackage;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } cic_state_t;

    // Internal width N*log2(R)+1 holds the full CIC gain R^N without ambiguity.
    function automatic int cic_width(input int r, input int n);
        return n * $clog2(r) + 1;
    endfunction

    function automatic int cic_out_shift(input int w, input int dl);
        return w - 1 - dl;
    endfunction

    function automatic logic [63:0] cic_half_gain(input int r, input int n);
        return 64'd1 << (n * $clog2(r) - 1);
    endfunction

endpackage

// File: rtl/sd_cic_decimator_integrator.sv
// rtl/sd_cic_decimator_integrator.sv - one modulo-2^W CIC integrator stage with clear and enable
module cic_integrator
    import SDCICPackage::*;
#(
    parameter int WIDTH = cic_width(64, 3)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] acc_o
);

    logic [WIDTH-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + in_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/sd_cic_decimator.sv
// rtl/sd_cic_decimator.sv - third-order CIC decimator from 1-bit modulator stream to FIFO samples
module sd_cic_decimator
    import SDCICPackage::*;
#(
    parameter int DATA_LENGTH     = 16,
    parameter int DECIMATION      = 64,
    parameter int ORDER           = 3,
    parameter int DROP_CNT_LENGTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_enable,
    input  logic                       i_bit,
    input  logic                       i_bit_valid,
    input  logic                       i_full,
    output logic [DATA_LENGTH-1:0]     o_data,
    output logic                       o_write,
    output logic                       o_busy,
    output logic                       o_overflow,
    output logic [DROP_CNT_LENGTH-1:0] o_drop_count
);

    localparam int W          = cic_width(DECIMATION, ORDER);
    localparam int CNT_W      = $clog2(DECIMATION);
    localparam int SC_W       = $clog2(ORDER + 1);
    localparam int SHIFT      = cic_out_shift(W, DATA_LENGTH);
    localparam int unsigned RSH = (SHIFT > 0) ? SHIFT : 0;
    localparam int unsigned LSH = (SHIFT < 0) ? -SHIFT : 0;
    localparam int XW         = W + 1 + DATA_LENGTH;
    localparam logic [W:0] HALF = (W + 1)'(cic_half_gain(DECIMATION, ORDER));
    localparam logic signed [XW-1:0] SAT_MAX = (XW'(1) <<< (DATA_LENGTH - 1)) - XW'(1);
    localparam logic signed [XW-1:0] SAT_MIN = -(XW'(1) <<< (DATA_LENGTH - 1));

    cic_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           dec_cnt_q, dec_cnt_d;
    logic [SC_W-1:0]            settle_cnt_q, settle_cnt_d;
    logic                       dec_strobe_q;
    logic [W-1:0]               comb_dly_q [ORDER];
    logic [W-1:0]               comb_tap [ORDER];
    logic [W-1:0]               comb_result;
    logic [W-1:0]               comb_out_q;
    logic                       comb_valid_q;
    logic [DATA_LENGTH-1:0]     data_q;
    logic                       write_q;
    logic                       overflow_q;
    logic [DROP_CNT_LENGTH-1:0] drop_cnt_q;

    logic                       accept;
    logic                       dec_wrap;
    logic [W-1:0]               integ_in [ORDER];
    logic [W-1:0]               integ_acc [ORDER];
    logic signed [W:0]          centered;
    logic signed [XW-1:0]       shifted;
    logic [DATA_LENGTH-1:0]     sat_data;

    assign accept   = i_bit_valid && i_enable && (state_q != IDLE);
    assign dec_wrap = accept && (dec_cnt_q == CNT_W'(DECIMATION - 1));

    assign integ_in[0] = {{(W - 1){1'b0}}, i_bit};

    for (genvar k = 0; k < ORDER; k++) begin : g_integ
        if (k > 0) begin : g_chain
            assign integ_in[k] = integ_acc[k-1];
        end
        cic_integrator #(.WIDTH(W)) u_integ (
            .clk   (clk),
            .reset (reset),
            .clr_i (!i_enable),
            .en_i  (accept),
            .in_i  (integ_in[k]),
            .acc_o (integ_acc[k])
        );
    end

    // Comb cascade evaluated on the strobe; comb_tap[k] is what delay k stores.
    always_comb begin
        logic [W-1:0] stage;
        stage = integ_acc[ORDER-1];
        for (int k = 0; k < ORDER; k++) begin
            comb_tap[k] = stage;
            stage       = stage - comb_dly_q[k];
        end
        comb_result = stage;
    end

    always_comb begin
        centered = {1'b0, comb_out_q} - HALF;
        shifted  = (XW'(centered) >>> RSH) <<< LSH;
        if (shifted > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_LENGTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_LENGTH-1:0];
        end else begin
            sat_data = shifted[DATA_LENGTH-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        dec_cnt_d    = accept ? dec_cnt_q + CNT_W'(1) : dec_cnt_q;
        case (state_q)
            IDLE: begin
                settle_cnt_d = '0;
                if (i_enable) state_d = SETTLE;
            end
            SETTLE: begin
                if (dec_strobe_q) begin
                    if (settle_cnt_q == SC_W'(ORDER - 1)) state_d = RUN;
                    else settle_cnt_d = settle_cnt_q + SC_W'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            dec_cnt_q    <= '0;
            settle_cnt_q <= '0;
            dec_strobe_q <= 1'b0;
            for (int k = 0; k < ORDER; k++) comb_dly_q[k] <= '0;
            comb_out_q   <= '0;
            comb_valid_q <= 1'b0;
            data_q       <= '0;
            write_q      <= 1'b0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else if (!i_enable) begin
            // Drop statistics survive a disable; only the filter path is cleared.
            state_q      <= IDLE;
            dec_cnt_q    <= '0;
            settle_cnt_q <= '0;
            dec_strobe_q <= 1'b0;
            for (int k = 0; k < ORDER; k++) comb_dly_q[k] <= '0;
            comb_out_q   <= '0;
            comb_valid_q <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            dec_cnt_q    <= dec_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            dec_strobe_q <= dec_wrap;
            if (dec_strobe_q) begin
                for (int k = 0; k < ORDER; k++) comb_dly_q[k] <= comb_tap[k];
                comb_out_q <= comb_result;
            end
            comb_valid_q <= dec_strobe_q && (state_q == RUN);
            write_q      <= comb_valid_q && !i_full;
            if (comb_valid_q && !i_full) begin
                data_q <= sat_data;
            end
            if (comb_valid_q && i_full) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_CNT_LENGTH'(1);
            end
        end
    end

    assign o_data       = data_q;
    assign o_write      = write_q;
    assign o_busy       = (state_q != IDLE);
    assign o_overflow   = overflow_q;
    assign o_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_sd_cic_decimator.sv
// tb/tb_sd_cic_decimator.sv - scoreboard bench for sd_cic_decimator
module tb_sd_cic_decimator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_bit = 1'b0;
    logic        i_bit_valid = 1'b0;
    logic        i_full = 1'b0;
    logic [15:0] o_data;
    logic        o_write;
    logic        o_busy;
    logic        o_overflow;
    logic [7:0]  o_drop_count;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          acc_bits = 0;
    int          frame_no = 0;
    bit          no_push = 1'b0;
    logic [15:0] last_data = 16'h0;

    sd_cic_decimator #(
        .DATA_LENGTH(16), .DECIMATION(64), .ORDER(3), .DROP_CNT_LENGTH(8)
    ) dut (
        .clk(clk), .reset(reset), .i_enable(i_enable), .i_bit(i_bit),
        .i_bit_valid(i_bit_valid), .i_full(i_full), .o_data(o_data),
        .o_write(o_write), .o_busy(o_busy), .o_overflow(o_overflow),
        .o_drop_count(o_drop_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic logic [15:0] exp_val(input int pattern);
        case (pattern)
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            default: return 16'h0000;
        endcase
    endfunction

    // pattern: 0 all zeros, 1 all ones, 2 alternating; gap = cycles between accepted bits
    task automatic send_bits(input int nbits, input int pattern, input int gap);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            i_bit       = (pattern == 0) ? 1'b0 : (pattern == 1) ? 1'b1 : i[0];
            i_bit_valid = 1'b1;
            acc_bits++;
            if (acc_bits % 64 == 0) begin
                frame_no++;
                if (frame_no > 3 && !i_full && !no_push)
                    sb.push_back('{exp_val(pattern), cyc + 3});
            end
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #1;
                i_bit_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        i_bit_valid = 1'b0;
    endtask

    task automatic start(input string name);
        @(posedge clk); #1;
        i_enable = 1'b1;
        acc_bits = 0;
        frame_no = 0;
        @(negedge clk);
        chk({name, "_busy_before"}, o_busy, 0);
        @(negedge clk);
        chk({name, "_busy_after"}, o_busy, 1);
    endtask

    task automatic stop(input string name);
        repeat (5) @(posedge clk);
        #1 i_enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_busy_off"}, o_busy, 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            last_data = 16'h0;
        end else if (o_write) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("wr_data", int'(o_data), int'(e.data));
                chk("wr_cycle", cyc, e.cyc);
            end
            last_data = o_data;
        end else begin
            chk("data_hold", int'(o_data), int'(last_data));
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", int'(o_data), 0);
        chk("rst_write", o_write, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_drop", int'(o_drop_count), 0);
        #1 reset = 1'b0;

        start("ones");
        send_bits(8 * 64, 1, 1);
        stop("ones");
        chk("ones_ovf", o_overflow, 0);

        start("zeros");
        send_bits(7 * 64, 0, 1);
        stop("zeros");

        start("alt");
        send_bits(7 * 64, 2, 1);
        stop("alt");

        start("sparse");
        send_bits(6 * 64, 1, 3);
        stop("sparse");

        i_full = 1'b1;
        start("full");
        send_bits(303 * 64, 1, 1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("full_ovf", o_overflow, 1);
        chk("full_drop", int'(o_drop_count), 255);
        i_full = 1'b0;
        send_bits(64, 1, 1);

        send_bits(32, 1, 1);
        stop("midframe");
        chk("midframe_drop", int'(o_drop_count), 255);
        chk("midframe_ovf", o_overflow, 1);
        start("restart");
        send_bits(5 * 64, 1, 1);

        no_push = 1'b1;
        send_bits(64, 1, 1);
        #0 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_write", o_write, 0);
        chk("rstmid_data", int'(o_data), 0);
        chk("rstmid_busy", o_busy, 0);
        chk("rstmid_ovf", o_overflow, 0);
        chk("rstmid_drop", int'(o_drop_count), 0);
        reset = 1'b0;
        no_push = 1'b0;
        acc_bits = 0;
        frame_no = 0;
        @(negedge clk);
        chk("rstmid_busy_resume", o_busy, 1);
        send_bits(5 * 64, 1, 1);

        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
